// File: rtl/exe_mdu_iter.sv
// Iterative RV64M/RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MDU_FAST_MUL_EN to compute multiplies with a single-cycle combinational product.
module exe_mdu_iter #(
   parameter int XLEN = 64,
   parameter int RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic            in_word,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [RD_W-1:0] in_rd_addr,
   input  logic            out_stall,
   output logic            out_valid,
   output logic [XLEN-1:0] out_data,
   output logic [RD_W-1:0] out_rd_addr,
   output logic            busy
);
   // state | meaning
   // IDLE  | waiting for an op, in_ready high unless flushing
   // CALC  | one multiply/divide bit per cycle, cnt counts down to 0
   // DONE  | result held on out_data until out_stall drops
   localparam int CW = $clog2(XLEN);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt;
   logic [2:0]          op_q;
   logic                word_q, neg_q, rneg_q;
   logic [RD_W-1:0]     rd_q;
   logic [2*XLEN-1:0]   a_reg, p_reg, p_mul, p_div, p_nxt;
   logic [XLEN-1:0]     b_reg;
   logic                word_in, signed1, signed2, sgn1, sgn2, div0, direct, accept;
   logic [XLEN-1:0]     op1, op2, mag1, mag2, div0_res, direct_res;
   logic [XLEN:0]       r_sh, trial;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r = '0;
      r[31:0] = v;
      return r;
   endfunction

   // Turns a magnitude product or {rem, quo} pair into the architectural result.
   function automatic logic [XLEN-1:0] fmt(input logic [2*XLEN-1:0] p, input logic [2:0] op,
                                          input logic word, input logic neg, input logic rneg);
      logic [2*XLEN-1:0] pv;
      logic [XLEN-1:0]   r, quo, rem;
      pv  = neg ? -p : p;
      quo = neg ? -p[XLEN-1:0] : p[XLEN-1:0];
      rem = rneg ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
      if (op[2])                r = op[1] ? rem : quo;
      else if (op[1:0] == 2'd0) r = pv[XLEN-1:0];
      else if (word)            r = zext32(pv[63:32]);
      else                      r = pv[2*XLEN-1:XLEN];
      if (word) r = sext32(r[31:0]);
      return r;
   endfunction

   always_comb begin
      word_in  = (XLEN == 64) && in_word;
      signed1  = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
      signed2  = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
      op1      = word_in ? (signed1 ? sext32(in_rs1[31:0]) : zext32(in_rs1[31:0])) : in_rs1;
      op2      = word_in ? (signed2 ? sext32(in_rs2[31:0]) : zext32(in_rs2[31:0])) : in_rs2;
      sgn1     = signed1 & op1[XLEN-1];
      sgn2     = signed2 & op2[XLEN-1];
      mag1     = sgn1 ? -op1 : op1;
      mag2     = sgn2 ? -op2 : op2;
      div0     = in_op[2] && (op2 == '0);
      div0_res = in_op[1] ? op1 : '1;
`ifdef MDU_FAST_MUL_EN
      direct     = in_op[2] ? div0 : 1'b1;
      direct_res = in_op[2] ? div0_res
                 : fmt({{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2}, in_op, word_in, sgn1 ^ sgn2, sgn1);
`else
      direct     = div0;
      direct_res = div0_res;
`endif
   end

   // One iteration step for each algorithm; the divide keeps {rem, quo} in p_reg.
   always_comb begin
      p_mul = p_reg + (b_reg[0] ? a_reg : '0);
      r_sh  = {p_reg[2*XLEN-1:XLEN], p_reg[XLEN-1]};
      trial = r_sh - {1'b0, b_reg};
      if (!trial[XLEN]) p_div = {trial[XLEN-1:0], p_reg[XLEN-2:0], 1'b1};
      else              p_div = {r_sh[XLEN-1:0], p_reg[XLEN-2:0], 1'b0};
      p_nxt = op_q[2] ? p_div : p_mul;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = rst && !flush && (state == S_IDLE);
      accept    = in_valid && in_ready;
      busy      = (state != S_IDLE);
      out_valid = (state == S_DONE);
      case (state)
         S_IDLE:  if (accept) state_nxt = direct ? S_DONE : S_CALC;
         S_CALC:  if (cnt == '0) state_nxt = S_DONE;
         S_DONE:  if (!out_stall) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         op_q        <= '0;
         word_q      <= 1'b0;
         neg_q       <= 1'b0;
         rneg_q      <= 1'b0;
         rd_q        <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         p_reg       <= '0;
         out_data    <= '0;
         out_rd_addr <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q   <= in_op;
            word_q <= word_in;
            neg_q  <= sgn1 ^ sgn2;
            rneg_q <= sgn1;
            rd_q   <= in_rd_addr;
            cnt    <= word_in ? CW'(31) : CW'(XLEN-1);
            a_reg  <= {{XLEN{1'b0}}, mag1};
            b_reg  <= mag2;
            // Word divides left-align the dividend so 32 steps consume exactly its bits.
            p_reg  <= in_op[2] ? {{XLEN{1'b0}}, (word_in ? (mag1 << 32) : mag1)} : '0;
         end else if (state == S_CALC) begin
            cnt   <= cnt - 1'b1;
            p_reg <= p_nxt;
            a_reg <= a_reg << 1;
            if (!op_q[2]) b_reg <= b_reg >> 1;
         end
         if ((state != S_DONE) && (state_nxt == S_DONE)) begin
            out_data    <= (state == S_IDLE) ? direct_res : fmt(p_nxt, op_q, word_q, neg_q, rneg_q);
            out_rd_addr <= (state == S_IDLE) ? in_rd_addr : rd_q;
         end
      end
   end
endmodule

// File: tb/tb_exe_mdu_iter.sv
// Directed bench for exe_mdu_iter at XLEN=64: results, latencies, flush, stall and reset.
module tb_exe_mdu_iter;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_word, out_stall, out_valid, busy;
   logic [2:0]  in_op;
   logic [63:0] in_rs1, in_rs2, out_data;
   logic [4:0]  in_rd_addr, out_rd_addr;
   int          n_cmp = 0;
   int          n_bad = 0;

`ifdef MDU_FAST_MUL_EN
   localparam int MUL_LAT  = 1;
   localparam int MULW_LAT = 1;
`else
   localparam int MUL_LAT  = 65;
   localparam int MULW_LAT = 33;
`endif

   exe_mdu_iter #(.XLEN(64), .RD_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_word(in_word), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_rd_addr(in_rd_addr), .out_stall(out_stall), .out_valid(out_valid),
      .out_data(out_data), .out_rd_addr(out_rd_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   // Issues one op and returns cycles from accept edge to first out_valid plus the result.
   task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, output int lat, output logic [63:0] res, output logic [4:0] rdo);
      @(negedge clk);
      in_op = op; in_word = w; in_rs1 = a; in_rs2 = b; in_rd_addr = rd; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
      res = out_data;
      rdo = out_rd_addr;
   endtask

   task automatic finish_op();
      out_stall = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (in_ready) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_word = 1'b0;
      in_rs1 = '0; in_rs2 = '0; in_rd_addr = '0; out_stall = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
      n_cmp++; if (out_data !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", out_data); end
      n_cmp++; if (out_rd_addr !== 5'd0) begin n_bad++; $display("FAIL reset_rd: got %h expected 0", out_rd_addr); end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b expected 1", in_ready); end
   endtask

   task automatic test_div();
      int lat; logic [63:0] r; logic [4:0] rd;
      run_op(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd7, lat, r, rd);
      n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_bad++; $display("FAIL div_data: got %h expected fffffffffffffffa", r); end
      n_cmp++; if (lat !== 65) begin n_bad++; $display("FAIL div_latency: got %0d expected 65", lat); end
      n_cmp++; if (rd !== 5'd7) begin n_bad++; $display("FAIL div_rd: got %0d expected 7", rd); end
      finish_op();
      run_op(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd8, lat, r, rd);
      n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL rem_data: got %h expected fffffffffffffffe", r); end
      n_cmp++; if (rd !== 5'd8) begin n_bad++; $display("FAIL rem_rd: got %0d expected 8", rd); end
      finish_op();
      run_op(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd1, lat, r, rd);
      n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL remw_data: got %h expected ffffffffffffffff", r); end
      finish_op();
   endtask

   task automatic test_div_zero();
      int lat; logic [63:0] r; logic [4:0] rd;
      run_op(3'd5, 1'b0, 64'd7, 64'd0, 5'd2, lat, r, rd);
      n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL divu0_data: got %h expected ffffffffffffffff", r); end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL divu0_latency: got %0d expected 1", lat); end
      finish_op();
      run_op(3'd7, 1'b0, 64'd7, 64'd0, 5'd3, lat, r, rd);
      n_cmp++; if (r !== 64'd7) begin n_bad++; $display("FAIL remu0_data: got %h expected 7", r); end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL remu0_latency: got %0d expected 1", lat); end
      finish_op();
      run_op(3'd4, 1'b1, 64'd0, 64'd0, 5'd4, lat, r, rd);
      n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL divw0_data: got %h expected ffffffffffffffff", r); end
      finish_op();
   endtask

   task automatic test_overflow();
      int lat; logic [63:0] r; logic [4:0] rd;
      run_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, lat, r, rd);
      n_cmp++; if (r !== 64'h8000_0000_0000_0000) begin n_bad++; $display("FAIL div_ovf_data: got %h expected 8000000000000000", r); end
      finish_op();
      run_op(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, lat, r, rd);
      n_cmp++; if (r !== 64'h0) begin n_bad++; $display("FAIL rem_ovf_data: got %h expected 0", r); end
      finish_op();
   endtask

   task automatic test_mul();
      int lat; logic [63:0] r; logic [4:0] rd;
      run_op(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, lat, r, rd);
      n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL mulhu_data: got %h expected fffffffffffffffe", r); end
      n_cmp++; if (lat !== MUL_LAT) begin n_bad++; $display("FAIL mulhu_latency: got %0d expected %0d", lat, MUL_LAT); end
      finish_op();
      run_op(3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, lat, r, rd);
      n_cmp++; if (r !== 64'd1) begin n_bad++; $display("FAIL mul_data: got %h expected 1", r); end
      finish_op();
      run_op(3'd0, 1'b0, 64'd6, 64'd7, 5'd11, lat, r, rd);
      n_cmp++; if (r !== 64'd42) begin n_bad++; $display("FAIL mul_small: got %h expected 2a", r); end
      finish_op();
      run_op(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd12, lat, r, rd);
      n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL mulh_data: got %h expected ffffffffffffffff", r); end
      finish_op();
      run_op(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, lat, r, rd);
      n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL mulhsu_data: got %h expected ffffffffffffffff", r); end
      finish_op();
      run_op(3'd3, 1'b0, 64'h0000_0001_0000_0000, 64'h0000_0003_0000_0000, 5'd14, lat, r, rd);
      n_cmp++; if (r !== 64'd3) begin n_bad++; $display("FAIL mulhu_mid: got %h expected 3", r); end
      finish_op();
   endtask

   task automatic test_word();
      int lat; logic [63:0] r; logic [4:0] rd;
      run_op(3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 5'd15, lat, r, rd);
      n_cmp++; if (r !== 64'hFFFF_FFFF_C000_0000) begin n_bad++; $display("FAIL divw_data: got %h expected ffffffffc0000000", r); end
      n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL divw_latency: got %0d expected 33", lat); end
      finish_op();
      run_op(3'd5, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 5'd16, lat, r, rd);
      n_cmp++; if (r !== 64'h0000_0000_4000_0000) begin n_bad++; $display("FAIL divuw_data: got %h expected 40000000", r); end
      finish_op();
      run_op(3'd0, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'h1234_0000_0000_0002, 5'd17, lat, r, rd);
      n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL mulw_data: got %h expected fffffffffffffffe", r); end
      n_cmp++; if (lat !== MULW_LAT) begin n_bad++; $display("FAIL mulw_latency: got %0d expected %0d", lat, MULW_LAT); end
      finish_op();
   endtask

   task automatic test_flush();
      int seen;
      @(negedge clk);
      in_op = 3'd4; in_word = 1'b0; in_rs1 = 64'd1000; in_rs2 = 64'd3; in_rd_addr = 5'd20; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before: got %b expected 1", busy); end
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy_after: got %b expected 0", busy); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready_after: got %b expected 1", in_ready); end
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_no_valid: got %0d valid cycles expected 0", seen); end
      // flush in the same cycle as a request must block the accept
      @(negedge clk);
      in_op = 3'd5; in_rs1 = 64'd9; in_rs2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready_gate: got %b expected 0", in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_accept_blocked: got %b expected 0", busy); end
   endtask

   task automatic test_stall();
      int lat; logic [63:0] r; logic [4:0] rd;
      out_stall = 1'b1;
      run_op(3'd5, 1'b0, 64'd7, 64'd0, 5'd21, lat, r, rd);
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL stall_latency: got %0d expected 1", lat); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
         n_cmp++; if (out_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL stall_data[%0d]: got %h expected ffffffffffffffff", i, out_data); end
         n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, in_ready); end
      end
      out_stall = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release_valid: got %b expected 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_rst_mid();
      @(negedge clk);
      in_op = 3'd4; in_word = 1'b0; in_rs1 = 64'd500; in_rs2 = 64'd7; in_rd_addr = 5'd22; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
      n_cmp++; if (out_data !== 64'h0) begin n_bad++; $display("FAIL rst_mid_data: got %h expected 0", out_data); end
      n_cmp++; if (out_rd_addr !== 5'd0) begin n_bad++; $display("FAIL rst_mid_rd: got %0d expected 0", out_rd_addr); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ready: got %b expected 0", in_ready); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_div();
      test_div_zero();
      test_overflow();
      test_mul();
      test_word();
      test_flush();
      test_stall();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
